// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the iterative multiply/divide unit
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MUL   = 2'b00,
      OP_UMULL = 2'b01,
      OP_SMULL = 2'b10,
      OP_UDIV  = 2'b11
   } muldiv_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_FIN  = 2'b10
   } muldiv_state_t;

   // {N, Z} reported when UDIV is compiled out
   localparam logic [1:0] FAST_FLAGS = 2'b01;

endpackage

// File: rtl/muldiv_post.sv
// rtl/muldiv_post.sv - combinational FIN stage: SMULL sign fix, result select, N/Z flags
// Divider results are only produced when MULDIV_DIV_EN is defined.
module muldiv_post
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  muldiv_op_t       op_i,
   input  logic [WIDTH-1:0] hi_i,
   input  logic [WIDTH-1:0] lo_i,
   input  logic             neg_i,
   input  logic             div_zero_i,
   output logic [WIDTH-1:0] res_lo_o,
   output logic [WIDTH-1:0] res_hi_o,
   output logic [1:0]       flags_o,
   output logic             div_zero_o
);

   logic [2*WIDTH-1:0] prod;

   always_comb begin
      prod       = (op_i == OP_SMULL && neg_i) ? -{hi_i, lo_i} : {hi_i, lo_i};
      res_lo_o   = prod[WIDTH-1:0];
      res_hi_o   = prod[2*WIDTH-1:WIDTH];
      flags_o    = {prod[2*WIDTH-1], prod == '0};
      div_zero_o = div_zero_i;
      unique case (op_i)
         OP_MUL: begin
            res_hi_o = '0;
            flags_o  = {lo_i[WIDTH-1], lo_i == '0};
         end
         OP_UDIV: begin
`ifdef MULDIV_DIV_EN
            // on divide-by-zero the dividend was never shifted out of lo
            res_lo_o = div_zero_i ? '0 : lo_i;
            res_hi_o = div_zero_i ? lo_i : hi_i;
            flags_o  = div_zero_i ? 2'b01 : {lo_i[WIDTH-1], lo_i == '0};
`else
            res_lo_o = '0;
            res_hi_o = '0;
            flags_o  = FAST_FLAGS;
`endif
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - radix-2 iterative MUL/UMULL/SMULL/UDIV unit beside the ALU
// UDIV hardware is present only when MULDIV_DIV_EN is defined.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] ResultLo,
   output logic [WIDTH-1:0] ResultHi,
   output logic [1:0]       Flags,
   output logic             DivZero
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   muldiv_state_t    state_q;
   muldiv_op_t       op_q;
   logic [WIDTH-1:0] m_q, hi_q, lo_q;
   logic [CNT_W-1:0] cnt_q;
   logic             neg_q, dz_q;
   logic             busy_q, done_q, divzero_q;
   logic [WIDTH-1:0] res_lo_q, res_hi_q;
   logic [1:0]       flags_q;

   muldiv_op_t       op_in;
   logic [WIDTH-1:0] abs_a, abs_b;
   logic             dz_in, fast_in;
   logic [WIDTH-1:0] hi_d, lo_d;
   logic [WIDTH:0]   sum;

   logic [WIDTH-1:0] post_lo, post_hi;
   logic [1:0]       post_flags;
   logic             post_dz;

   always_comb begin
      op_in = muldiv_op_t'(Op);
      abs_a = (op_in == OP_SMULL && SrcA[WIDTH-1]) ? -SrcA : SrcA;
      abs_b = (op_in == OP_SMULL && SrcB[WIDTH-1]) ? -SrcB : SrcB;
`ifdef MULDIV_DIV_EN
      dz_in   = (op_in == OP_UDIV) && (SrcB == '0);
      fast_in = dz_in;
`else
      dz_in   = 1'b0;
      fast_in = (op_in == OP_UDIV);
`endif
   end

   // One radix-2 step: hi holds partial product or remainder, lo holds multiplier or quotient
`ifdef MULDIV_DIV_EN
   logic [WIDTH:0] rem_sh;
`endif
   always_comb begin
      sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
      rem_sh = {hi_q, lo_q[WIDTH-1]};
      if (op_q == OP_UDIV) begin
         if (rem_sh >= {1'b0, m_q}) begin
            hi_d = rem_sh[WIDTH-1:0] - m_q;
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            hi_d = rem_sh[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
         end
      end
`endif
   end

   muldiv_post #(.WIDTH(WIDTH)) u_post (
      .op_i       (op_q),
      .hi_i       (hi_q),
      .lo_i       (lo_q),
      .neg_i      (neg_q),
      .div_zero_i (dz_q),
      .res_lo_o   (post_lo),
      .res_hi_o   (post_hi),
      .flags_o    (post_flags),
      .div_zero_o (post_dz)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_MUL;
         m_q       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         dz_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         divzero_q <= 1'b0;
         res_lo_q  <= '0;
         res_hi_q  <= '0;
         flags_q   <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (Start) begin
                  op_q   <= op_in;
                  neg_q  <= (op_in == OP_SMULL) && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                  dz_q   <= dz_in;
                  cnt_q  <= '0;
                  hi_q   <= '0;
                  busy_q <= 1'b1;
                  if (op_in == OP_UDIV) begin
                     m_q  <= SrcB;
                     lo_q <= SrcA;
                  end else begin
                     m_q  <= abs_a;
                     lo_q <= abs_b;
                  end
                  state_q <= fast_in ? ST_FIN : ST_RUN;
               end
            end
            ST_RUN: begin
               hi_q  <= hi_d;
               lo_q  <= lo_d;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= ST_FIN;
            end
            ST_FIN: begin
               res_lo_q  <= post_lo;
               res_hi_q  <= post_hi;
               flags_q   <= post_flags;
               divzero_q <= post_dz;
               done_q    <= 1'b1;
               busy_q    <= 1'b0;
               state_q   <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign Busy     = busy_q;
   assign Done     = done_q;
   assign ResultLo = res_lo_q;
   assign ResultHi = res_hi_q;
   assign Flags    = flags_q;
   assign DivZero  = divzero_q;

endmodule
